// File: rtl/leaky_relu_pkg.sv
// Shared parameters and state encoding for the leaky-ReLU output sequencer.
package leaky_relu_pkg;

    localparam int N_COLS = 4;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lr_deskew_fifo.sv
// Single-column deskew FIFO: registered push/pop with flush, head visible combinationally.
module lr_deskew_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates its visibility and the
    // top masks the row output while it is not valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/leaky_relu_ctrl.sv
// Leaky-ReLU stage sequencer: latches job config, deskews column outputs into rows,
// and writes one aligned row per handshake to consecutive unified-buffer addresses.
module leaky_relu_ctrl
    import leaky_relu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int ROW_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [DATA_W-1:0]        cfg_leak_factor,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic [ROW_W-1:0]         cfg_num_rows,
    output logic [DATA_W-1:0]        lr_leak_factor_out,
    input  logic [N_COLS-1:0]        lr_valid_in,
    input  logic [N_COLS*DATA_W-1:0] lr_data_in,
    output logic                     ub_wr_valid,
    input  logic                     ub_wr_ready,
    output logic [ADDR_W-1:0]        ub_wr_addr,
    output logic [N_COLS*DATA_W-1:0] ub_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overflow
);

    state_t                   state;
    logic [ADDR_W-1:0]        base_addr;
    logic [ROW_W-1:0]         num_rows;
    logic [ROW_W-1:0]         row_cnt;
    logic [N_COLS-1:0]        push;
    logic [N_COLS-1:0]        full;
    logic [N_COLS-1:0]        empty;
    logic [N_COLS-1:0]        drop;
    logic [N_COLS*DATA_W-1:0] head_row;
    logic                     start_acc;
    logic                     flush;
    logic                     row_avail;
    logic                     xfer;
    logic                     last_row;
    logic                     stray_valid;

    assign start_acc   = (state == IDLE) && cfg_start;
    assign flush       = start_acc || (state == DONE);
    assign push        = (state == RUN) ? lr_valid_in : '0;
    assign row_avail   = (state == RUN) && (empty == '0);
    assign xfer        = row_avail && ub_wr_ready;
    assign last_row    = (row_cnt == num_rows - ROW_W'(1));
    // A full FIFO still accepts a push when the row is leaving in the same cycle.
    assign drop        = push & full & ~{N_COLS{xfer}};
    assign stray_valid = (state != RUN) && (|lr_valid_in);

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        lr_deskew_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push[c]),
            .pop      (xfer),
            .data_in  (lr_data_in[c*DATA_W +: DATA_W]),
            .data_out (head_row[c*DATA_W +: DATA_W]),
            .full     (full[c]),
            .empty    (empty[c])
        );
    end

    assign ub_wr_valid = row_avail;
    assign ub_wr_data  = row_avail ? head_row : '0;
    assign ub_wr_addr  = base_addr + ADDR_W'(row_cnt);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            lr_leak_factor_out <= '0;
            base_addr          <= '0;
            num_rows           <= '0;
            row_cnt            <= '0;
            err_overflow       <= 1'b0;
        end else begin
            if (start_acc) begin
                err_overflow <= 1'b0;
            end else if ((|drop) || stray_valid) begin
                err_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        lr_leak_factor_out <= cfg_leak_factor;
                        base_addr          <= cfg_base_addr;
                        num_rows           <= cfg_num_rows;
                        row_cnt            <= '0;
                        state              <= (cfg_num_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (last_row) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaky_relu_ctrl.sv
// Scoreboard bench for leaky_relu_ctrl: directed jobs push expected writes, a monitor checks them.
module tb_leaky_relu_ctrl;
    import leaky_relu_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int ROW_W    = 8;
    localparam int ROW_BITS = N_COLS * DATA_W;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [ROW_BITS-1:0] data;
        logic [DATA_W-1:0]   leak;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                cfg_start;
    logic [DATA_W-1:0]   cfg_leak_factor;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [ROW_W-1:0]    cfg_num_rows;
    logic [DATA_W-1:0]   lr_leak_factor_out;
    logic [N_COLS-1:0]   lr_valid_in;
    logic [ROW_BITS-1:0] lr_data_in;
    logic                ub_wr_valid;
    logic                ub_wr_ready;
    logic [ADDR_W-1:0]   ub_wr_addr;
    logic [ROW_BITS-1:0] ub_wr_data;
    logic                busy;
    logic                done;
    logic                err_overflow;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    logic [DATA_W-1:0] skew_rows [2][4] = '{'{16'h0011, 16'h0012, 16'h0013, 16'h0014},
                                            '{16'h0021, 16'h0022, 16'h0023, 16'h0024}};

    leaky_relu_ctrl #(
        .ADDR_W     (ADDR_W),
        .ROW_W      (ROW_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start          (cfg_start),
        .cfg_leak_factor    (cfg_leak_factor),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_num_rows       (cfg_num_rows),
        .lr_leak_factor_out (lr_leak_factor_out),
        .lr_valid_in        (lr_valid_in),
        .lr_data_in         (lr_data_in),
        .ub_wr_valid        (ub_wr_valid),
        .ub_wr_ready        (ub_wr_ready),
        .ub_wr_addr         (ub_wr_addr),
        .ub_wr_data         (ub_wr_data),
        .busy               (busy),
        .done               (done),
        .err_overflow       (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_row(input logic [ADDR_W-1:0] addr, input logic [ROW_BITS-1:0] data,
                              input logic [DATA_W-1:0] leak);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.leak = leak;
        sb.push_back(e);
    endtask

    task automatic start_job(input logic [DATA_W-1:0] leak, input logic [ADDR_W-1:0] base,
                             input logic [ROW_W-1:0] rows);
        cfg_leak_factor = leak;
        cfg_base_addr   = base;
        cfg_num_rows    = rows;
        cfg_start       = 1'b1;
        tick();
        cfg_start       = 1'b0;
    endtask

    task automatic push_row(input logic [N_COLS-1:0] mask, input logic [ROW_BITS-1:0] data);
        lr_valid_in = mask;
        lr_data_in  = data;
        tick();
        lr_valid_in = '0;
        lr_data_in  = '0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            tick();
            check({name, "_done_one_cycle"}, 64'(done), 64'd0);
            check({name, "_busy_after"}, 64'(busy), 64'd0);
        end
    endtask

    // Monitor: every transfer must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) done_cnt++;
        if (rst && ub_wr_valid && ub_wr_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 64'(ub_wr_addr), 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(ub_wr_addr), 64'(e.addr));
                check("wr_data", ub_wr_data, e.data);
                check("wr_leak", 64'(lr_leak_factor_out), 64'(e.leak));
            end
        end
    end

    initial begin
        rst             = 1'b0;
        cfg_start       = 1'b0;
        cfg_leak_factor = '0;
        cfg_base_addr   = '0;
        cfg_num_rows    = '0;
        lr_valid_in     = '0;
        lr_data_in      = '0;
        ub_wr_ready     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ub_wr_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        check("rst_leak", 64'(lr_leak_factor_out), 64'd0);
        check("rst_addr", 64'(ub_wr_addr), 64'd0);
        check("rst_data", ub_wr_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Aligned job.
        ub_wr_ready = 1'b1;
        start_job(16'h0080, 8'h10, 8'd3);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_leak", 64'(lr_leak_factor_out), 64'h0080);
        expect_row(8'h10, pack4(16'd1, 16'd2, 16'd3, 16'd4), 16'h0080);
        expect_row(8'h11, pack4(16'd5, 16'd6, 16'd7, 16'd8), 16'h0080);
        expect_row(8'h12, pack4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC), 16'h0080);
        push_row(4'hF, pack4(16'd1, 16'd2, 16'd3, 16'd4));
        push_row(4'hF, pack4(16'd5, 16'd6, 16'd7, 16'd8));
        push_row(4'hF, pack4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
        wait_done("t1");
        check("t1_leak_after", 64'(lr_leak_factor_out), 64'h0080);
        check("t1_err", 64'(err_overflow), 64'd0);

        // Skewed input: column c lags column 0 by c cycles.
        start_job(16'h0100, 8'h20, 8'd2);
        expect_row(8'h20, pack4(16'h0011, 16'h0012, 16'h0013, 16'h0014), 16'h0100);
        expect_row(8'h21, pack4(16'h0021, 16'h0022, 16'h0023, 16'h0024), 16'h0100);
        for (int k = 0; k < 5; k++) begin
            lr_valid_in = '0;
            lr_data_in  = '0;
            for (int c = 0; c < N_COLS; c++) begin
                if (k - c >= 0 && k - c < 2) begin
                    lr_valid_in[c]               = 1'b1;
                    lr_data_in[c*DATA_W +: DATA_W] = skew_rows[k-c][c];
                end
            end
            tick();
            if (k == 2) check("t2_valid_before_col3", 64'(ub_wr_valid), 64'd0);
            if (k == 3) check("t2_valid_after_col3", 64'(ub_wr_valid), 64'd1);
        end
        lr_valid_in = '0;
        lr_data_in  = '0;
        wait_done("t2");

        // Backpressure mid-job.
        start_job(16'h0033, 8'h30, 8'd3);
        expect_row(8'h30, pack4(16'h0101, 16'h0102, 16'h0103, 16'h0104), 16'h0033);
        expect_row(8'h31, pack4(16'h0201, 16'h0202, 16'h0203, 16'h0204), 16'h0033);
        expect_row(8'h32, pack4(16'h0301, 16'h0302, 16'h0303, 16'h0304), 16'h0033);
        push_row(4'hF, pack4(16'h0101, 16'h0102, 16'h0103, 16'h0104));
        push_row(4'hF, pack4(16'h0201, 16'h0202, 16'h0203, 16'h0204));
        ub_wr_ready = 1'b0;
        push_row(4'hF, pack4(16'h0301, 16'h0302, 16'h0303, 16'h0304));
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 64'(ub_wr_valid), 64'd1);
            check("t3_hold_addr", 64'(ub_wr_addr), 64'h31);
            check("t3_hold_data", ub_wr_data, pack4(16'h0201, 16'h0202, 16'h0203, 16'h0204));
            tick();
        end
        ub_wr_ready = 1'b1;
        wait_done("t3");
        check("t3_err", 64'(err_overflow), 64'd0);

        // Overflow on column 0: the fifth push is dropped.
        ub_wr_ready = 1'b0;
        start_job(16'h0044, 8'h40, 8'd1);
        expect_row(8'h40, pack4(16'h00A1, 16'h00B1, 16'h00B2, 16'h00B3), 16'h0044);
        for (int i = 0; i < 5; i++) begin
            push_row(4'b0001, pack4(16'h00A1 + 16'(i), 16'h0, 16'h0, 16'h0));
            if (i == 3) check("t4_err_at_depth", 64'(err_overflow), 64'd0);
            if (i == 4) check("t4_err_overflow", 64'(err_overflow), 64'd1);
        end
        push_row(4'b1110, pack4(16'h0, 16'h00B1, 16'h00B2, 16'h00B3));
        check("t4_valid", 64'(ub_wr_valid), 64'd1);
        ub_wr_ready = 1'b1;
        wait_done("t4");
        check("t4_err_sticky", 64'(err_overflow), 64'd1);

        // Zero-row job: done one cycle after start, error cleared by the start.
        start_job(16'h0055, 8'h00, 8'd0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_err_cleared", 64'(err_overflow), 64'd0);
        tick();
        check("t5_done_one_cycle", 64'(done), 64'd0);

        // Address wrap, with a start during RUN that must be ignored.
        start_job(16'h0066, 8'hFE, 8'd3);
        cfg_leak_factor = 16'h7777;
        cfg_base_addr   = 8'h99;
        cfg_num_rows    = 8'd9;
        cfg_start       = 1'b1;
        tick();
        cfg_start       = 1'b0;
        check("t6_leak_kept", 64'(lr_leak_factor_out), 64'h0066);
        check("t6_busy", 64'(busy), 64'd1);
        expect_row(8'hFE, pack4(16'h0601, 16'h0602, 16'h0603, 16'h0604), 16'h0066);
        expect_row(8'hFF, pack4(16'h0611, 16'h0612, 16'h0613, 16'h0614), 16'h0066);
        expect_row(8'h00, pack4(16'h0621, 16'h0622, 16'h0623, 16'h0624), 16'h0066);
        push_row(4'hF, pack4(16'h0601, 16'h0602, 16'h0603, 16'h0604));
        push_row(4'hF, pack4(16'h0611, 16'h0612, 16'h0613, 16'h0614));
        push_row(4'hF, pack4(16'h0621, 16'h0622, 16'h0623, 16'h0624));
        wait_done("t6");

        // Reset with a row pending, then a fresh job on empty FIFOs.
        ub_wr_ready = 1'b0;
        start_job(16'h0077, 8'h50, 8'd2);
        push_row(4'hF, pack4(16'h0701, 16'h0702, 16'h0703, 16'h0704));
        check("t7_pending", 64'(ub_wr_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 64'(ub_wr_valid), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_addr", 64'(ub_wr_addr), 64'd0);
        check("t7_rst_data", ub_wr_data, 64'd0);
        check("t7_rst_leak", 64'(lr_leak_factor_out), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        ub_wr_ready = 1'b1;
        start_job(16'h0088, 8'h60, 8'd1);
        check("t7_fifos_empty", 64'(ub_wr_valid), 64'd0);
        expect_row(8'h60, pack4(16'h0801, 16'h0802, 16'h0803, 16'h0804), 16'h0088);
        push_row(4'b0111, pack4(16'h0801, 16'h0802, 16'h0803, 16'h0));
        check("t7_partial_row", 64'(ub_wr_valid), 64'd0);
        push_row(4'b1000, pack4(16'h0, 16'h0, 16'h0, 16'h0804));
        wait_done("t7");

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
